// File: rtl/collision_pkg.sv
// Shared scanner state encoding and default playfield geometry.
package collision_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int DEF_DISPLAY_WIDTH    = 240;
  localparam int DEF_DISPLAY_HEIGHT   = 320;
  localparam int DEF_BORDER_THICKNESS = 20;
  localparam int DEF_SEG_WIDTH        = 10;
  localparam int DEF_SEG_HEIGHT       = 10;
  localparam int DEF_APPLE_WIDTH      = 10;
  localparam int DEF_APPLE_HEIGHT     = 10;

  localparam int DEF_X_WIDTH          = 8;
  localparam int DEF_Y_WIDTH          = 9;
  localparam int DEF_MAX_SEGMENTS     = 128;

endpackage

// File: rtl/rect_overlap.sv
// Strict rectangle overlap: a shared pixel is a hit, abutting edges are not.
module rect_overlap #(
  parameter int XWidth  = 8,
  parameter int YWidth  = 9,
  parameter int AWidth  = 10,
  parameter int AHeight = 10,
  parameter int BWidth  = 10,
  parameter int BHeight = 10
) (
  input  logic [XWidth-1:0] a_x,
  input  logic [YWidth-1:0] a_y,
  input  logic [XWidth-1:0] b_x,
  input  logic [YWidth-1:0] b_y,
  output logic              overlap
);

  // One extra bit so right/bottom edges never wrap.
  logic [XWidth:0] ax_lo, bx_lo, ax_hi, bx_hi;
  logic [YWidth:0] ay_lo, by_lo, ay_hi, by_hi;

  assign ax_lo = {1'b0, a_x};
  assign bx_lo = {1'b0, b_x};
  assign ay_lo = {1'b0, a_y};
  assign by_lo = {1'b0, b_y};
  assign ax_hi = ax_lo + (XWidth+1)'(AWidth);
  assign bx_hi = bx_lo + (XWidth+1)'(BWidth);
  assign ay_hi = ay_lo + (YWidth+1)'(AHeight);
  assign by_hi = by_lo + (YWidth+1)'(BHeight);

  assign overlap = (ax_lo < bx_hi) && (bx_lo < ax_hi) &&
                   (ay_lo < by_hi) && (by_lo < ay_hi);

endmodule

// File: rtl/collision_scanner.sv
// Sequential head-vs-wall/apple/body collision scanner; walls and apples in one
// cycle, then the body Lanes segments per cycle, stopping at the first hit.
module collision_scanner
  import collision_pkg::*;
#(
  parameter int SegWidth        = DEF_SEG_WIDTH,
  parameter int SegHeight       = DEF_SEG_HEIGHT,
  parameter int BorderThickness = DEF_BORDER_THICKNESS,
  parameter int DisplayWidth    = DEF_DISPLAY_WIDTH,
  parameter int DisplayHeight   = DEF_DISPLAY_HEIGHT,
  parameter int AppleWidth      = DEF_APPLE_WIDTH,
  parameter int AppleHeight     = DEF_APPLE_HEIGHT,
  parameter int XWidth          = DEF_X_WIDTH,
  parameter int YWidth          = DEF_Y_WIDTH,
  parameter int MaxSegments     = DEF_MAX_SEGMENTS,
  parameter int NumApples       = 2,
  parameter int Lanes           = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          check,
  input  logic [MaxSegments*XWidth-1:0] snakeLocX,
  input  logic [MaxSegments*YWidth-1:0] snakeLocY,
  input  logic [7:0]                    size,
  input  logic [NumApples*XWidth-1:0]   appleLocX,
  input  logic [NumApples*YWidth-1:0]   appleLocY,
  output logic                          busy,
  output logic                          done,
  output logic                          collision,
  output logic                          wallHit,
  output logic                          bodyHit,
  output logic [7:0]                    hitSegment,
  output logic [NumApples-1:0]          appleEaten
);

  localparam int IdxW = $clog2(MaxSegments + Lanes + 1);
  localparam int SelW = (MaxSegments > 1) ? $clog2(MaxSegments) : 1;

  state_e                      state_q;
  logic [IdxW-1:0]             idx_q;
  logic [XWidth-1:0]           head_x_q;
  logic [YWidth-1:0]           head_y_q;
  logic [NumApples*XWidth-1:0] apple_x_q;
  logic [NumApples*YWidth-1:0] apple_y_q;
  logic                        busy_q, done_q, coll_q, wall_q, body_q;
  logic [7:0]                  hit_seg_q;
  logic [NumApples-1:0]        apple_eaten_q;

  logic [IdxW-1:0]             eff;
  logic                        wall_hit;
  logic [NumApples-1:0]        apple_hit;
  logic [Lanes-1:0]            lane_hit;
  logic [IdxW-1:0]             lane_idx [Lanes];
  logic                        body_any;
  logic [IdxW-1:0]             first_idx;
  logic [XWidth-1:0]           seg_x [MaxSegments];
  logic [YWidth-1:0]           seg_y [MaxSegments];
  logic [XWidth:0]             head_x_end;
  logic [YWidth:0]             head_y_end;

  always_comb begin
    eff = (int'(size) > MaxSegments) ? IdxW'(MaxSegments) : IdxW'(size);
  end

  assign head_x_end = {1'b0, head_x_q} + (XWidth+1)'(SegWidth);
  assign head_y_end = {1'b0, head_y_q} + (YWidth+1)'(SegHeight);
  assign wall_hit =
      ({1'b0, head_x_q} < (XWidth+1)'(BorderThickness)) ||
      (head_x_end > (XWidth+1)'(DisplayWidth - BorderThickness)) ||
      ({1'b0, head_y_q} < (YWidth+1)'(BorderThickness)) ||
      (head_y_end > (YWidth+1)'(DisplayHeight - BorderThickness));

  for (genvar s = 0; s < MaxSegments; s++) begin : g_seg
    assign seg_x[s] = snakeLocX[s*XWidth +: XWidth];
    assign seg_y[s] = snakeLocY[s*YWidth +: YWidth];
  end

  for (genvar a = 0; a < NumApples; a++) begin : g_apple
    rect_overlap #(
      .XWidth(XWidth), .YWidth(YWidth),
      .AWidth(SegWidth), .AHeight(SegHeight),
      .BWidth(AppleWidth), .BHeight(AppleHeight)
    ) u_apple (
      .a_x(head_x_q), .a_y(head_y_q),
      .b_x(apple_x_q[a*XWidth +: XWidth]), .b_y(apple_y_q[a*YWidth +: YWidth]),
      .overlap(apple_hit[a])
    );
  end

  // Lanes past the end of the vector read slot 0; the eff mask discards them.
  for (genvar l = 0; l < Lanes; l++) begin : g_lane
    logic [IdxW-1:0] seg;
    logic [SelW-1:0] sel;
    logic            raw;
    assign seg = idx_q + IdxW'(l);
    assign sel = (seg < IdxW'(MaxSegments)) ? SelW'(seg) : '0;
    rect_overlap #(
      .XWidth(XWidth), .YWidth(YWidth),
      .AWidth(SegWidth), .AHeight(SegHeight),
      .BWidth(SegWidth), .BHeight(SegHeight)
    ) u_body (
      .a_x(head_x_q), .a_y(head_y_q),
      .b_x(seg_x[sel]), .b_y(seg_y[sel]),
      .overlap(raw)
    );
    assign lane_hit[l] = raw && (seg < eff);
    assign lane_idx[l] = seg;
  end

  always_comb begin
    body_any  = 1'b0;
    first_idx = '0;
    for (int l = Lanes - 1; l >= 0; l--) begin
      if (lane_hit[l]) begin
        body_any  = 1'b1;
        first_idx = lane_idx[l];
      end
    end
  end

  // state   | meaning
  // IDLE    | waiting for check
  // HEAD    | wall and apple test on the snapshot
  // BODY    | scanning segments idx..idx+Lanes-1
  // DONE    | result strobe, back to IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= IdxW'(1);
      head_x_q      <= '0;
      head_y_q      <= '0;
      apple_x_q     <= '0;
      apple_y_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      coll_q        <= 1'b0;
      wall_q        <= 1'b0;
      body_q        <= 1'b0;
      hit_seg_q     <= '0;
      apple_eaten_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (check) begin
            head_x_q      <= seg_x[0];
            head_y_q      <= seg_y[0];
            apple_x_q     <= appleLocX;
            apple_y_q     <= appleLocY;
            apple_eaten_q <= '0;
            hit_seg_q     <= '0;
            busy_q        <= 1'b1;
            state_q       <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          apple_eaten_q <= apple_hit;
          if (wall_hit) begin
            wall_q <= 1'b1;
            coll_q <= 1'b1;
          end
          if (wall_hit || (eff <= IdxW'(1))) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= IdxW'(1);
            state_q <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (body_any) begin
            body_q    <= 1'b1;
            coll_q    <= 1'b1;
            hit_seg_q <= 8'(first_idx);
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
          end else if (({1'b0, idx_q} + (IdxW+1)'(Lanes)) >= {1'b0, eff}) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IdxW'(Lanes);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign collision  = coll_q;
  assign wallHit    = wall_q;
  assign bodyHit    = body_q;
  assign hitSegment = hit_seg_q;
  assign appleEaten = apple_eaten_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner: a Lanes=1 and a Lanes=2 instance share
// stimulus and are checked every cycle against a geometric reference model.
module tb_collision_scanner;

  localparam int MS = 128;
  localparam int XW = 8;
  localparam int YW = 9;
  localparam int NA = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            check = 1'b0;
  logic [MS*XW-1:0] snake_x;
  logic [MS*YW-1:0] snake_y;
  logic [7:0]       size;
  logic [NA*XW-1:0] apple_x;
  logic [NA*YW-1:0] apple_y;

  logic busy1, done1, coll1, wall1, body1;
  logic busy2, done2, coll2, wall2, body2;
  logic [7:0] hs1, hs2;
  logic [NA-1:0] ae1, ae2;

  collision_scanner #(.Lanes(1)) dut1 (
    .clock(clock), .reset(reset), .check(check),
    .snakeLocX(snake_x), .snakeLocY(snake_y), .size(size),
    .appleLocX(apple_x), .appleLocY(apple_y),
    .busy(busy1), .done(done1), .collision(coll1), .wallHit(wall1),
    .bodyHit(body1), .hitSegment(hs1), .appleEaten(ae1)
  );

  collision_scanner #(.Lanes(2)) dut2 (
    .clock(clock), .reset(reset), .check(check),
    .snakeLocX(snake_x), .snakeLocY(snake_y), .size(size),
    .appleLocX(apple_x), .appleLocY(apple_y),
    .busy(busy2), .done(done2), .collision(coll2), .wallHit(wall2),
    .bodyHit(body2), .hitSegment(hs2), .appleEaten(ae2)
  );

  always #5 clock = ~clock;

  int seg_x [MS];
  int seg_y [MS];
  int app_x [NA];
  int app_y [NA];
  int size_i;

  int checks = 0;
  int errors = 0;
  int exp_wall = 0, exp_body = 0, exp_hit = 0, exp_apples = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < MS; i++) begin
      snake_x[i*XW +: XW] = XW'(seg_x[i]);
      snake_y[i*YW +: YW] = YW'(seg_y[i]);
    end
    for (int a = 0; a < NA; a++) begin
      apple_x[a*XW +: XW] = XW'(app_x[a]);
      apple_y[a*YW +: YW] = YW'(app_y[a]);
    end
    size = 8'(size_i);
  endtask

  function automatic bit ov(input int ax, input int ay, input int bx, input int by);
    return (ax < bx + 10) && (bx < ax + 10) && (ay < by + 10) && (by < ay + 10);
  endfunction

  // Latency counted in cycles from the cycle that holds check high to done.
  task automatic predict(input int lanes, output int lat, output int wall,
                         output int hit, output int apples);
    int eff, b;
    eff    = (size_i > MS) ? MS : size_i;
    wall   = (seg_x[0] < 20 || seg_x[0] + 10 > 220 ||
              seg_y[0] < 20 || seg_y[0] + 10 > 300) ? 1 : 0;
    apples = 0;
    for (int a = 0; a < NA; a++)
      if (ov(seg_x[0], seg_y[0], app_x[a], app_y[a])) apples |= (1 << a);
    hit = 0;
    if (wall == 0)
      for (int i = 1; i < eff; i++)
        if (hit == 0 && ov(seg_x[0], seg_y[0], seg_x[i], seg_y[i])) hit = i;
    if (wall != 0 || eff <= 1) b = 0;
    else if (hit != 0)         b = (hit - 1) / lanes + 1;
    else                       b = (eff - 1 + lanes - 1) / lanes;
    lat = 2 + b;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy1"}, busy1, 0);  chk({tag, " done1"}, done1, 0);
    chk({tag, " coll1"}, coll1, 0);  chk({tag, " wall1"}, wall1, 0);
    chk({tag, " body1"}, body1, 0);  chk({tag, " hs1"}, hs1, 0);
    chk({tag, " ae1"}, ae1, 0);
    chk({tag, " busy2"}, busy2, 0);  chk({tag, " done2"}, done2, 0);
    chk({tag, " coll2"}, coll2, 0);  chk({tag, " wall2"}, wall2, 0);
    chk({tag, " body2"}, body2, 0);  chk({tag, " hs2"}, hs2, 0);
    chk({tag, " ae2"}, ae2, 0);
  endtask

  task automatic chk_flags(input string tag, input logic c, input logic w, input logic b,
                           input logic [7:0] hs, input logic [NA-1:0] ae);
    chk({tag, " collision"}, c, (exp_wall | exp_body));
    chk({tag, " wallHit"}, w, exp_wall);
    chk({tag, " bodyHit"}, b, exp_body);
    chk({tag, " hitSegment"}, hs, exp_hit);
    chk({tag, " appleEaten"}, ae, exp_apples);
  endtask

  // extra: 0 none, 1 re-pulse check into HEAD, 2 re-pulse check into DONE.
  task automatic run_check(input string tag, input int pin1, input int pin2,
                           input int pin_ap, input int extra);
    int lat1, lat2, w, hit, ap, last;
    apply();
    predict(1, lat1, w, hit, ap);
    predict(2, lat2, w, hit, ap);
    if (pin1 >= 0)   chk({tag, " model lat1"}, lat1, pin1);
    if (pin2 >= 0)   chk({tag, " model lat2"}, lat2, pin2);
    if (pin_ap >= 0) chk({tag, " model apples"}, ap, pin_ap);
    exp_wall   |= w;
    exp_body   |= (hit != 0) ? 1 : 0;
    exp_hit    = hit;
    exp_apples = ap;
    last = ((lat1 > lat2) ? lat1 : lat2) + 1;
    @(negedge clock);
    check = 1'b1;
    @(posedge clock);
    for (int k = 0; k <= last; k++) begin
      @(negedge clock);
      check = ((extra == 1 && k == 0) || (extra == 2 && k == lat2 - 1)) ? 1'b1 : 1'b0;
      chk($sformatf("%s done1 k%0d", tag, k), done1, (k == lat1 - 1) ? 1 : 0);
      chk($sformatf("%s busy1 k%0d", tag, k), busy1, (k <= lat1 - 1) ? 1 : 0);
      chk($sformatf("%s done2 k%0d", tag, k), done2, (k == lat2 - 1) ? 1 : 0);
      chk($sformatf("%s busy2 k%0d", tag, k), busy2, (k <= lat2 - 1) ? 1 : 0);
      if (k == lat1 - 1) chk_flags({tag, " L1"}, coll1, wall1, body1, hs1, ae1);
      if (k == lat2 - 1) chk_flags({tag, " L2"}, coll2, wall2, body2, hs2, ae2);
    end
    check = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    exp_wall = 0; exp_body = 0; exp_hit = 0; exp_apples = 0;
    chk_idle(tag);
    reset = 1'b0;
  endtask

  task automatic set_head(input int x, input int y);
    seg_x[0] = x;
    seg_y[0] = y;
  endtask

  task automatic clear_body();
    for (int i = 1; i < MS; i++) begin
      seg_x[i] = 150;
      seg_y[i] = 250;
    end
  endtask

  int wx_miss [4] = '{20, 210, 100, 100};
  int wy_miss [4] = '{100, 100, 20, 290};
  int wx_hit  [4] = '{19, 211, 100, 100};
  int wy_hit  [4] = '{100, 100, 19, 291};
  int gx [7] = '{21, 39, 30, 20, 40, 30, 30};
  int gy [7] = '{30, 30, 21, 30, 30, 20, 40};
  int ge [7] = '{1, 1, 1, 0, 0, 0, 0};

  initial begin
    clear_body();
    set_head(30, 30);
    app_x[0] = 100; app_y[0] = 200;
    app_x[1] = 180; app_y[1] = 150;
    size_i = 1;
    apply();

    // Reset held two cycles with a check pulse inside it.
    @(negedge clock);
    check = 1'b1;
    @(negedge clock);
    check = 1'b0;
    chk_idle("reset");
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("post-reset done1 k%0d", k), done1, 0);
      chk($sformatf("post-reset busy1 k%0d", k), busy1, 0);
    end

    for (int i = 0; i < 4; i++) begin
      set_head(wx_miss[i], wy_miss[i]);
      run_check($sformatf("wall miss %0d", i), 2, 2, -1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      set_head(wx_hit[i], wy_hit[i]);
      run_check($sformatf("wall hit %0d", i), 2, 2, -1, 0);
    end
    do_reset("reset after walls");

    set_head(30, 30);
    for (int i = 0; i < 7; i++) begin
      app_x[0] = gx[i];
      app_y[0] = gy[i];
      run_check($sformatf("glance %0d", i), 2, 2, ge[i], 0);
    end

    app_x[0] = 30; app_y[0] = 30;
    app_x[1] = 70; app_y[1] = 70;
    seg_x[1] = 40; seg_y[1] = 40;
    seg_x[2] = 50; seg_y[2] = 50;
    seg_x[3] = 60; seg_y[3] = 60;
    size_i = 4;
    run_check("apple hit", 5, 4, 1, 1);
    chk("apple hit collision", coll1, 0);

    app_x[0] = 100; app_y[0] = 200;
    app_x[1] = 180; app_y[1] = 150;
    set_head(110, 100);
    seg_x[1] = 110; seg_y[1] = 100;
    seg_x[2] = 120; seg_y[2] = 100;
    seg_x[3] = 130; seg_y[3] = 100;
    run_check("body seg1", 3, 3, 0, 2);

    seg_x[1] = 130; seg_y[1] = 100;
    seg_x[2] = 140; seg_y[2] = 100;
    seg_x[3] = 115; seg_y[3] = 105;
    run_check("body seg3", 5, 4, 0, 0);
    chk("body seg3 hitSegment L2", hs2, 3);

    clear_body();
    set_head(30, 30);
    run_check("clean after hit", 5, 4, 0, 0);
    chk("sticky collision L1", coll1, 1);
    chk("sticky bodyHit L2", body2, 1);

    size_i = 200;
    run_check("size clamp", 129, 66, 0, 0);

    // Reset in the middle of the body scan.
    apply();
    @(negedge clock);
    check = 1'b1;
    @(negedge clock);
    check = 1'b0;
    repeat (2) @(negedge clock);
    chk("mid-scan busy1", busy1, 1);
    reset = 1'b1;
    #1;
    exp_wall = 0; exp_body = 0; exp_hit = 0; exp_apples = 0;
    chk_idle("mid-scan reset");
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 140; k++) begin
      @(negedge clock);
      if (k % 20 == 0 || done1 || done2) begin
        chk($sformatf("aborted done1 k%0d", k), done1, 0);
        chk($sformatf("aborted done2 k%0d", k), done2, 0);
      end
    end

    set_head(110, 100);
    seg_x[1] = 110; seg_y[1] = 100;
    size_i = 4;
    run_check("after abort", 3, 3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
